// File: rtl/xc_wb_fwd_pipe_if.sv
// Execute-to-writeback handshake, forwarding ports, register-file write port
// and scoreboard signals of the writeback forwarding pipe.
interface xc_wb_fwd_pipe_if;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_wen;
  logic        ex_wide;
  logic [4:0]  ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_wdata_hi;
  logic        rd_hold;

  logic        fwd_0_wen;
  logic        fwd_0_wide;
  logic [4:0]  fwd_0_addr;
  logic [31:0] fwd_0_wdata;
  logic [31:0] fwd_0_wdata_hi;

  logic        fwd_1_wen;
  logic        fwd_1_wide;
  logic [4:0]  fwd_1_addr;
  logic [31:0] fwd_1_wdata;
  logic [31:0] fwd_1_wdata_hi;

  logic        rd_wen;
  logic        rd_wide;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [31:0] rd_wdata_hi;

  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic        sb_set_wide;
  logic [31:0] sb_busy;

  // Execute / register-file side
  modport master (
    output flush, ex_valid, ex_wen, ex_wide, ex_addr, ex_wdata, ex_wdata_hi,
           rd_hold, sb_set, sb_set_addr, sb_set_wide,
    input  ex_ready,
           fwd_0_wen, fwd_0_wide, fwd_0_addr, fwd_0_wdata, fwd_0_wdata_hi,
           fwd_1_wen, fwd_1_wide, fwd_1_addr, fwd_1_wdata, fwd_1_wdata_hi,
           rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi, sb_busy
  );

  // Writeback pipe side
  modport slave (
    input  flush, ex_valid, ex_wen, ex_wide, ex_addr, ex_wdata, ex_wdata_hi,
           rd_hold, sb_set, sb_set_addr, sb_set_wide,
    output ex_ready,
           fwd_0_wen, fwd_0_wide, fwd_0_addr, fwd_0_wdata, fwd_0_wdata_hi,
           fwd_1_wen, fwd_1_wide, fwd_1_addr, fwd_1_wdata, fwd_1_wdata_hi,
           rd_wen, rd_wide, rd_addr, rd_wdata, rd_wdata_hi, sb_busy
  );
endinterface

// File: rtl/xc_wb_fwd_pipe.sv
// Three-stage writeback pipe (S0/S1 forward, S2 writes the register file).
// Optional XC_WB_SCOREBOARD_EN adds a registered per-GPR pending-write vector.
module xc_wb_fwd_pipe (
  input  logic              clock,
  input  logic              resetn,
  xc_wb_fwd_pipe_if.slave   wb
);

  typedef struct packed {
    logic        wen;
    logic        wide;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] wdata_hi;
  } payload_t;

  logic     s0_vld_q, s0_vld_d;
  logic     s1_vld_q, s1_vld_d;
  logic     s2_vld_q, s2_vld_d;
  payload_t s0_q, s0_d;
  payload_t s1_q, s1_d;
  payload_t s2_q, s2_d;

  logic     retire;
  logic     adv_12;
  logic     adv_01;
  logic     ready;
  logic     accept;
  payload_t cap;
  payload_t s0_out;
  payload_t s1_out;
  payload_t s2_out;

  always_comb begin
    retire = s2_vld_q && !wb.rd_hold;
    adv_12 = s1_vld_q && (!s2_vld_q || retire);
    adv_01 = s0_vld_q && (!s1_vld_q || adv_12);
    ready  = !wb.flush && (!s0_vld_q || adv_01);
    accept = wb.ex_valid && ready;
  end

  // Non-writing payloads are stored as all-zero, because the register file
  // compares forward addresses without looking at wen.
  always_comb begin
    cap          = '0;
    cap.wen      = wb.ex_wen && (wb.ex_addr != 5'd0);
    cap.wide     = wb.ex_wide;
    cap.addr     = wb.ex_wide ? {wb.ex_addr[4:1], 1'b0} : wb.ex_addr;
    cap.wdata    = wb.ex_wdata;
    cap.wdata_hi = wb.ex_wide ? wb.ex_wdata_hi : wb.ex_wdata;
    if (!cap.wen) begin
      cap = '0;
    end
  end

  always_comb begin
    s0_vld_d = s0_vld_q;
    s0_d     = s0_q;
    if (wb.flush) begin
      s0_vld_d = 1'b0;
    end else if (accept) begin
      s0_vld_d = 1'b1;
      s0_d     = cap;
    end else if (adv_01) begin
      s0_vld_d = 1'b0;
    end
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (wb.flush) begin
      s1_vld_d = 1'b0;
    end else if (adv_01) begin
      s1_vld_d = 1'b1;
      s1_d     = s0_q;
    end else if (adv_12) begin
      s1_vld_d = 1'b0;
    end
  end

  // Flush kills S1 before it can reach S2; S2 itself still retires.
  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (adv_12 && !wb.flush) begin
      s2_vld_d = 1'b1;
      s2_d     = s1_q;
    end else if (retire) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s0_vld_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s0_vld_q <= s0_vld_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  always_comb begin
    s0_out = s0_vld_q ? s0_q : '0;
    s1_out = s1_vld_q ? s1_q : '0;
    s2_out = s2_vld_q ? s2_q : '0;
  end

  assign wb.ex_ready       = ready;

  assign wb.fwd_0_wen      = s0_out.wen;
  assign wb.fwd_0_wide     = s0_out.wide;
  assign wb.fwd_0_addr     = s0_out.addr;
  assign wb.fwd_0_wdata    = s0_out.wdata;
  assign wb.fwd_0_wdata_hi = s0_out.wdata_hi;

  assign wb.fwd_1_wen      = s1_out.wen;
  assign wb.fwd_1_wide     = s1_out.wide;
  assign wb.fwd_1_addr     = s1_out.addr;
  assign wb.fwd_1_wdata    = s1_out.wdata;
  assign wb.fwd_1_wdata_hi = s1_out.wdata_hi;

  // A held S2 still presents its destination; only the write strobe drops.
  assign wb.rd_wen         = s2_out.wen && !wb.rd_hold;
  assign wb.rd_wide        = s2_out.wide;
  assign wb.rd_addr        = s2_out.addr;
  assign wb.rd_wdata       = s2_out.wdata;
  assign wb.rd_wdata_hi    = s2_out.wdata_hi;

`ifdef XC_WB_SCOREBOARD_EN
  logic [31:0] sb_busy_q, sb_busy_d;
  logic [31:0] sb_set_mask;
  logic [31:0] sb_clr_mask;

  always_comb begin
    sb_set_mask = '0;
    sb_clr_mask = '0;
    if (wb.sb_set) begin
      if (wb.sb_set_wide) begin
        sb_set_mask[{wb.sb_set_addr[4:1], 1'b0}] = 1'b1;
        sb_set_mask[{wb.sb_set_addr[4:1], 1'b1}] = 1'b1;
      end else begin
        sb_set_mask[wb.sb_set_addr] = 1'b1;
      end
    end
    if (wb.rd_wen) begin
      if (wb.rd_wide) begin
        sb_clr_mask[{wb.rd_addr[4:1], 1'b0}] = 1'b1;
        sb_clr_mask[{wb.rd_addr[4:1], 1'b1}] = 1'b1;
      end else begin
        sb_clr_mask[wb.rd_addr] = 1'b1;
      end
    end
    // Set after clear so a same-cycle set wins; x0 is never pending.
    sb_busy_d    = (sb_busy_q & ~sb_clr_mask) | sb_set_mask;
    sb_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sb_busy_q <= '0;
    end else begin
      sb_busy_q <= sb_busy_d;
    end
  end

  assign wb.sb_busy = sb_busy_q;
`else
  logic sb_unused;
  assign sb_unused  = ^{wb.sb_set, wb.sb_set_addr, wb.sb_set_wide};
  assign wb.sb_busy = '0;
`endif

endmodule

// File: tb/tb_xc_wb_fwd_pipe.sv
// Randomized and directed bench for xc_wb_fwd_pipe against a slot-list model.
module tb_xc_wb_fwd_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xc_wb_fwd_pipe_if wb_if ();

  xc_wb_fwd_pipe dut (
    .clock  (clk),
    .resetn (rst_n),
    .wb     (wb_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit        v;
    bit        wen;
    bit        wide;
    bit [4:0]  a;
    bit [31:0] d;
    bit [31:0] dh;
  } ent_t;

  ent_t      m[3];
  ent_t      nx[3];
  bit [31:0] m_busy;
  bit        e_ready;
  bit        e_rdw;

  function automatic logic [70:0] pl(input ent_t e);
    if (e.v && e.wen) return {1'b1, e.wide, e.a, e.d, e.dh};
    return '0;
  endfunction

  function automatic bit [31:0] pair_mask(input bit [4:0] a, input bit wide);
    bit [31:0] r;
    r = '0;
    if (wide) begin
      r[a & 5'h1e] = 1'b1;
      r[a | 5'h01] = 1'b1;
    end else begin
      r[a] = 1'b1;
    end
    return r;
  endfunction

  // Results move forward one slot whenever the slot ahead is free after
  // retirement; the entrance is open only if slot 0 ends up free.
  task automatic compute();
    nx = m;
    e_rdw = nx[2].v && nx[2].wen && !wb_if.rd_hold;
    if (nx[2].v && !wb_if.rd_hold) nx[2].v = 1'b0;
    if (wb_if.flush) begin
      nx[0].v = 1'b0;
      nx[1].v = 1'b0;
    end
    for (int i = 2; i > 0; i--) begin
      if (!nx[i].v && nx[i-1].v) begin
        nx[i] = nx[i-1];
        nx[i-1].v = 1'b0;
      end
    end
    e_ready = !wb_if.flush && !nx[0].v;
    if (wb_if.ex_valid && e_ready) begin
      nx[0].v    = 1'b1;
      nx[0].wen  = wb_if.ex_wen && (wb_if.ex_addr != 5'd0);
      nx[0].wide = wb_if.ex_wide;
      nx[0].a    = wb_if.ex_wide ? (wb_if.ex_addr & 5'h1e) : wb_if.ex_addr;
      nx[0].d    = wb_if.ex_wdata;
      nx[0].dh   = wb_if.ex_wide ? wb_if.ex_wdata_hi : wb_if.ex_wdata;
    end
  endtask

  task automatic check_outputs();
    logic [70:0] exp_rd;
    compute();
    check("ex_ready", wb_if.ex_ready, e_ready);
    check("fwd0", {wb_if.fwd_0_wen, wb_if.fwd_0_wide, wb_if.fwd_0_addr,
                   wb_if.fwd_0_wdata, wb_if.fwd_0_wdata_hi}, pl(m[0]));
    check("fwd1", {wb_if.fwd_1_wen, wb_if.fwd_1_wide, wb_if.fwd_1_addr,
                   wb_if.fwd_1_wdata, wb_if.fwd_1_wdata_hi}, pl(m[1]));
    exp_rd = pl(m[2]);
    exp_rd[70] = e_rdw;
    check("rd", {wb_if.rd_wen, wb_if.rd_wide, wb_if.rd_addr,
                 wb_if.rd_wdata, wb_if.rd_wdata_hi}, exp_rd);
`ifdef XC_WB_SCOREBOARD_EN
    check("sb_busy", wb_if.sb_busy, m_busy);
`else
    check("sb_busy", wb_if.sb_busy, 71'd0);
`endif
  endtask

  task automatic advance();
    bit [31:0] clr, set;
    if (!rst_n) begin
      foreach (m[i]) m[i] = '{default: 0};
      m_busy = '0;
    end else begin
      clr = e_rdw ? pair_mask(m[2].a, m[2].wide) : 32'd0;
      set = wb_if.sb_set ? pair_mask(wb_if.sb_set_addr, wb_if.sb_set_wide) : 32'd0;
      m_busy = (m_busy & ~clr) | set;
      m_busy[0] = 1'b0;
      m = nx;
    end
  endtask

  task automatic set_in(input bit v, input bit wen, input bit wide, input bit [4:0] a,
                        input bit [31:0] d, input bit [31:0] dh, input bit hold,
                        input bit fl, input bit sbs, input bit [4:0] sba, input bit sbw);
    wb_if.ex_valid    = v;
    wb_if.ex_wen      = wen;
    wb_if.ex_wide     = wide;
    wb_if.ex_addr     = a;
    wb_if.ex_wdata    = d;
    wb_if.ex_wdata_hi = dh;
    wb_if.rd_hold     = hold;
    wb_if.flush       = fl;
    wb_if.sb_set      = sbs;
    wb_if.sb_set_addr = sba;
    wb_if.sb_set_wide = sbw;
  endtask

  task automatic drv(input bit v, input bit wen, input bit wide, input bit [4:0] a,
                     input bit [31:0] d, input bit [31:0] dh, input bit hold,
                     input bit fl, input bit sbs, input bit [4:0] sba, input bit sbw);
    @(negedge clk);
    set_in(v, wen, wide, a, d, dh, hold, fl, sbs, sba, sbw);
    #1;
    check_outputs();
  endtask

  task automatic step(input bit v, input bit wen, input bit wide, input bit [4:0] a,
                      input bit [31:0] d, input bit [31:0] dh, input bit hold,
                      input bit fl, input bit sbs, input bit [4:0] sba, input bit sbw);
    drv(v, wen, wide, a, d, dh, hold, fl, sbs, sba, sbw);
    advance();
  endtask

  task automatic put(input bit [4:0] a, input bit [31:0] d);
    step(1, 1, 0, a, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input bit hold);
    step(0, 0, 0, 0, 0, 0, hold, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    advance();
    check_outputs();
    check("rst_rd_wen", wb_if.rd_wen, 0);
    check("rst_ready", wb_if.ex_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Narrow result to x5: one stage per cycle
    put(5'd5, 32'hA5A5_0001);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_fwd0_addr", wb_if.fwd_0_addr, 5);
    advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_fwd1_addr", wb_if.fwd_1_addr, 5);
    advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_rd", {wb_if.rd_wen, wb_if.rd_addr, wb_if.rd_wdata, wb_if.rd_wdata_hi},
          {1'b1, 5'd5, 32'hA5A5_0001, 32'hA5A5_0001});
    advance();

    // Wide result to x7 lands on pair x6/x7
    step(1, 1, 1, 5'd7, 32'h1111, 32'h2222, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_rd", {wb_if.rd_wen, wb_if.rd_wide, wb_if.rd_addr, wb_if.rd_wdata, wb_if.rd_wdata_hi},
          {1'b1, 1'b1, 5'd6, 32'h1111, 32'h2222});
    check("t2_idle_fwd", {wb_if.fwd_0_addr, wb_if.fwd_1_addr, wb_if.fwd_0_wdata}, 0);
    advance();

    // Back-to-back x3,x4,x5 then hold for 4 cycles
    put(5'd3, 32'h3);
    put(5'd4, 32'h4);
    put(5'd5, 32'h5);
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 0, 5'd6, 32'h6, 0, 1, 0, 0, 0, 0);
      check("t3_held", {wb_if.ex_ready, wb_if.rd_wen, wb_if.rd_addr, wb_if.fwd_1_addr, wb_if.fwd_0_addr},
            {1'b0, 1'b0, 5'd3, 5'd4, 5'd5});
      advance();
    end
    for (int i = 3; i <= 5; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t3_order", {wb_if.rd_wen, wb_if.rd_addr}, {1'b1, 5'(i)});
      advance();
    end

    // Flush with x7 in S2, x8 in S1, x9 in S0
    put(5'd7, 32'h7);
    put(5'd8, 32'h8);
    put(5'd9, 32'h9);
    drv(1, 1, 0, 5'd10, 32'hA, 0, 0, 1, 0, 0, 0);
    check("t4_flush_rd", {wb_if.ex_ready, wb_if.rd_wen, wb_if.rd_addr}, {1'b0, 1'b1, 5'd7});
    advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_after_flush", {wb_if.fwd_0_addr, wb_if.fwd_1_addr, wb_if.rd_wen}, 0);
    advance();
    repeat (2) idle(0);

    // Write to x0 is suppressed everywhere
    put(5'd0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t5_x0", {wb_if.rd_wen, wb_if.fwd_0_addr, wb_if.fwd_1_addr, wb_if.rd_addr}, 0);
      advance();
    end

    // Scoreboard set/clear
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef XC_WB_SCOREBOARD_EN
    check("t6_sb_set", wb_if.sb_busy[11:10], 2'b11);
`endif
    advance();
    step(1, 1, 1, 5'd10, 32'h10, 32'h11, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    idle(0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef XC_WB_SCOREBOARD_EN
    check("t6_sb_clr", wb_if.sb_busy[11:10], 2'b00);
`endif
    advance();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 0);
    put(5'd10, 32'h10);
    idle(0);
    idle(0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 0);
    check("t6_rd_x10", {wb_if.rd_wen, wb_if.rd_addr}, {1'b1, 5'd10});
    advance();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef XC_WB_SCOREBOARD_EN
    check("t6_set_wins", wb_if.sb_busy[10], 1'b1);
`endif
    advance();

    // Reset while full: nothing survives, no write on release
    put(5'd1, 32'h1);
    put(5'd2, 32'h2);
    put(5'd3, 32'h3);
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t7_no_write", wb_if.rd_wen, 0);
    advance();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      bit [4:0] a;
      bit       w;
      a = 5'($urandom_range(0, 31));
      w = ($urandom_range(0, 9) < 3);
      if (w && a == 5'd1) a = 5'd3;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9, w, a,
           $urandom, $urandom, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 2, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
